// File: rtl/linsys_pkg.sv
// Shared types and job geometry for the 3x3 linear-solver host adapter.
package linsys_pkg;

    typedef enum logic [2:0] {
        S_CLR,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_WAIT,
        S_SEND
    } state_t;

    localparam int N_A   = 9;
    localparam int N_B   = 3;
    localparam int N_X   = 3;
    localparam int N_JOB = N_A + N_B;

endpackage

// File: rtl/linsys_timeout_ctr.sv
// Solver watchdog: cleared before each run, counts while enabled, flags the final waiting cycle.
module linsys_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (TIMEOUT_CYCLES != 0)) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the cycle whose increment would take the count to TIMEOUT_CYCLES-1,
    // so the caller leaves the wait exactly TIMEOUT_CYCLES cycles after the start pulse.
    assign expire = enable && (TIMEOUT_CYCLES != 0) &&
                    ((32'(count) + 32'd2) >= 32'(TIMEOUT_CYCLES));

endmodule

// File: rtl/linsys_host_adapter.sv
// Host-side adapter for the 3x3 linear solver: streams a job into the solver's A/b
// write ports, starts it under a watchdog and streams x0..x2 back with last/err.
module linsys_host_adapter
    import linsys_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CLR_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  out_err,
    output logic                  slv_rst,
    output logic                  slv_start,
    output logic [DATA_WIDTH-1:0] a_data,
    output logic [3:0]            a_addr,
    output logic                  a_wen,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic [1:0]            b_addr,
    output logic                  b_wen,
    input  logic [DATA_WIDTH-1:0] slv_x0,
    input  logic [DATA_WIDTH-1:0] slv_x1,
    input  logic [DATA_WIDTH-1:0] slv_x2,
    input  logic                  slv_done,
    output logic                  busy
);

    // state   | meaning
    // S_CLR   | solver held in reset for CLR_CYCLES cycles
    // S_LOAD  | accepting the 12 job words, one write strobe per accept
    // S_FLUSH | final b write visible, start pulse being issued
    // S_START | start pulse visible, watchdog cleared
    // S_WAIT  | waiting for slv_done or watchdog expiry
    // S_SEND  | streaming x0..x2 to the host

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_t                state;
    logic [CLR_W-1:0]      clr_cnt;
    logic [3:0]            k;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] res [N_X];
    logic                  wd_expire;

    linsys_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk   (clk),
        .rst   (rst),
        .clear (state == S_START),
        .enable(state == S_WAIT),
        .expire(wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLR;
            clr_cnt   <= '0;
            k         <= '0;
            idx       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            slv_rst   <= 1'b1;
            slv_start <= 1'b0;
            a_wen     <= 1'b0;
            a_addr    <= '0;
            a_data    <= '0;
            b_wen     <= 1'b0;
            b_addr    <= '0;
            b_data    <= '0;
            busy      <= 1'b1;
            for (int i = 0; i < N_X; i++) res[i] <= '0;
        end else begin
            a_wen     <= 1'b0;
            b_wen     <= 1'b0;
            slv_start <= 1'b0;
            case (state)
                S_CLR: begin
                    slv_rst <= 1'b1;
                    if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                        clr_cnt  <= '0;
                        slv_rst  <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        k        <= '0;
                        state    <= S_LOAD;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        busy <= 1'b1;
                        if (k < 4'(N_A)) begin
                            a_wen  <= 1'b1;
                            a_addr <= k;
                            a_data <= in_data;
                        end else begin
                            b_wen  <= 1'b1;
                            b_addr <= 2'(k - 4'(N_A));
                            b_data <= in_data;
                        end
                        if (k == 4'(N_JOB - 1)) begin
                            in_ready <= 1'b0;
                            state    <= S_FLUSH;
                        end
                        k <= k + 4'd1;
                    end
                end
                S_FLUSH: begin
                    slv_start <= 1'b1;
                    state     <= S_START;
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a simultaneous watchdog expiry
                    if (slv_done) begin
                        res[0]    <= slv_x0;
                        res[1]    <= slv_x1;
                        res[2]    <= slv_x2;
                        out_data  <= slv_x0;
                        out_err   <= 1'b0;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= S_SEND;
                    end else if (wd_expire) begin
                        for (int i = 0; i < N_X; i++) res[i] <= '0;
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (idx == 2'(N_X - 1)) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_err   <= 1'b0;
                            out_data  <= '0;
                            slv_rst   <= 1'b1;
                            clr_cnt   <= '0;
                            state     <= S_CLR;
                        end else begin
                            idx      <= idx + 2'd1;
                            out_data <= res[idx + 2'd1];
                            out_last <= (idx == 2'(N_X - 2));
                        end
                    end
                end
                default: begin
                    slv_rst <= 1'b1;
                    clr_cnt <= '0;
                    state   <= S_CLR;
                end
            endcase
        end
    end

endmodule
